// File: rtl/flashmem_pkg.sv
// Shared definitions for the flash-emulation memory arbiter: FSM states, requester IDs,
// window defaults and the address-window decode.
package flashmem_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StErr   = 3'd3,
    StResp  = 3'd4
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  localparam logic [3:0]  DefBaseNibble = 4'h1;
  localparam int unsigned DefAddrBits   = 13;
  localparam int unsigned DefWinBytes   = 32768;

  function automatic logic in_window(input logic [23:0] addr, input logic [3:0] base,
                                     input int unsigned win_bytes);
    return (addr[23:20] == base) && ({12'd0, addr[19:0]} < win_bytes);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on a tie the requester that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o,
  output logic       any_o
);

  always_comb begin
    any_o = |req_i;
    if (&req_i) begin
      grant_o = ~last_i;
    end else begin
      grant_o = req_i[1];
    end
  end

endmodule

// File: rtl/flashmem_arbiter.sv
// Arbitrates the CPU read port and the image-loader port onto one synchronous-read memory,
// turning its registered-address read timing into a per-port valid/ready pulse.
module flashmem_arbiter
  import flashmem_pkg::*;
#(
  parameter logic [3:0]  BASE_NIBBLE = DefBaseNibble,
  parameter int unsigned ADDR_BITS   = DefAddrBits,
  parameter int unsigned WIN_BYTES   = DefWinBytes
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 c_valid,
  output logic                 c_ready,
  input  logic [23:0]          c_addr,
  output logic [31:0]          c_rdata,
  input  logic                 l_valid,
  output logic                 l_ready,
  input  logic [23:0]          l_addr,
  input  logic [3:0]           l_wstrb,
  input  logic [31:0]          l_wdata,
  output logic [31:0]          l_rdata,
  input  logic                 l_lock,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_wren,
  output logic [3:0]           mem_byteena,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_q,
  output logic                 owner
);

  state_e                 state_q;
  logic                   owner_q;
  logic                   c_ready_q, l_ready_q;
  logic [31:0]            c_rdata_q, l_rdata_q;
  logic [ADDR_BITS-1:0]   mem_addr_q;
  logic                   mem_wren_q;
  logic [3:0]             mem_byteena_q;
  logic [31:0]            mem_wdata_q;

  logic [1:0]  req;
  logic        grant, any;
  logic [23:0] sel_addr;
  logic        sel_in;
  logic        sel_write;

  assign req       = {l_valid, c_valid & ~l_lock};
  assign sel_addr  = (grant == REQ_LDR) ? l_addr : c_addr;
  assign sel_in    = in_window(sel_addr, BASE_NIBBLE, WIN_BYTES);
  assign sel_write = (grant == REQ_LDR) && (l_wstrb != 4'h0);

  rr_arb2 u_arb (
    .req_i   (req),
    .last_i  (owner_q),
    .grant_o (grant),
    .any_o   (any)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      owner_q       <= REQ_LDR;
      c_ready_q     <= 1'b0;
      l_ready_q     <= 1'b0;
      c_rdata_q     <= '0;
      l_rdata_q     <= '0;
      mem_addr_q    <= '0;
      mem_wren_q    <= 1'b0;
      mem_byteena_q <= 4'h0;
      mem_wdata_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any) begin
            owner_q <= grant;
            if (sel_in) begin
              mem_addr_q    <= sel_addr[ADDR_BITS+1:2];
              mem_wdata_q   <= (grant == REQ_LDR) ? l_wdata : 32'h0;
              mem_byteena_q <= sel_write ? l_wstrb : 4'hF;
              mem_wren_q    <= sel_write;
              state_q       <= StIssue;
            end else begin
              // Out-of-window: no memory cycle, answer with zero data.
              state_q <= StErr;
            end
          end
        end
        StIssue: begin
          mem_wren_q <= 1'b0;
          state_q    <= StWait;
        end
        StWait: begin
          if (owner_q == REQ_LDR) begin
            l_rdata_q <= mem_q;
            l_ready_q <= 1'b1;
          end else begin
            c_rdata_q <= mem_q;
            c_ready_q <= 1'b1;
          end
          state_q <= StResp;
        end
        StErr: begin
          if (owner_q == REQ_LDR) begin
            l_rdata_q <= '0;
            l_ready_q <= 1'b1;
          end else begin
            c_rdata_q <= '0;
            c_ready_q <= 1'b1;
          end
          state_q <= StResp;
        end
        StResp: begin
          c_ready_q <= 1'b0;
          l_ready_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign c_ready     = c_ready_q;
  assign l_ready     = l_ready_q;
  assign c_rdata     = c_rdata_q;
  assign l_rdata     = l_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wren    = mem_wren_q;
  assign mem_byteena = mem_byteena_q;
  assign mem_wdata   = mem_wdata_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_flashmem_arbiter.sv
// Scoreboard bench for flashmem_arbiter: drivers push expected responses, a negedge monitor
// pops and compares whenever a ready pulse appears.
module tb_flashmem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        c_valid, c_ready;
  logic [23:0] c_addr;
  logic [31:0] c_rdata;
  logic        l_valid, l_ready;
  logic [23:0] l_addr;
  logic [3:0]  l_wstrb;
  logic [31:0] l_wdata, l_rdata;
  logic        l_lock;
  logic [12:0] mem_addr;
  logic        mem_wren;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_wdata, mem_q;
  logic        owner;

  always #5 clk = ~clk;

  flashmem_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .c_valid     (c_valid),
    .c_ready     (c_ready),
    .c_addr      (c_addr),
    .c_rdata     (c_rdata),
    .l_valid     (l_valid),
    .l_ready     (l_ready),
    .l_addr      (l_addr),
    .l_wstrb     (l_wstrb),
    .l_wdata     (l_wdata),
    .l_rdata     (l_rdata),
    .l_lock      (l_lock),
    .mem_addr    (mem_addr),
    .mem_wren    (mem_wren),
    .mem_byteena (mem_byteena),
    .mem_wdata   (mem_wdata),
    .mem_q       (mem_q),
    .owner       (owner)
  );

  typedef struct {
    logic [31:0] data;
    bit          dc;
  } exp_t;

  logic [31:0] mem   [8192];
  logic [31:0] model [8192];
  exp_t        cq[$];
  exp_t        lq[$];
  int          ready_log[$];
  int          errors = 0;
  int          checks = 0;
  int          c_cnt = 0, l_cnt = 0, wren_cnt = 0;
  logic [12:0] last_wren_addr = '0;
  logic [3:0]  last_wren_be = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the address decode and byte-lane merge, straight from the window rules.
  function automatic void push(input bit port, input logic [23:0] addr, input logic [3:0] wstrb,
                               input logic [31:0] wdata);
    exp_t  e;
    bit    in_win;
    int    idx;
    in_win = (addr[23:20] == 4'h1) && (int'(addr[19:0]) < 32768);
    idx    = int'(addr[19:0]) / 4;
    e.dc   = 1'b0;
    e.data = 32'h0;
    if (port && wstrb != 4'h0) begin
      if (in_win) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        e.dc = 1'b1;
      end
    end else if (in_win) begin
      e.data = model[idx];
    end
    if (port) lq.push_back(e);
    else cq.push_back(e);
  endfunction

  function automatic int exp_lat(input logic [23:0] addr);
    return ((addr[23:20] == 4'h1) && (int'(addr[19:0]) < 32768)) ? 3 : 2;
  endfunction

  // Synchronous-read memory: address and write sampled on the edge, q valid after it.
  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem[i]   = $urandom;
      model[i] = mem[i];
    end
    mem[1]   = 32'hDEADBEEF;
    model[1] = 32'hDEADBEEF;
    mem_q    = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_wren)
        for (int b = 0; b < 4; b++)
          if (mem_byteena[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_q <= mem[mem_addr];
    end
  end

  // Monitor
  initial begin
    logic [31:0] c_hold, l_hold;
    logic        prev_c, prev_l;
    exp_t        e;
    c_hold = '0; l_hold = '0; prev_c = 1'b0; prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        c_hold = '0; l_hold = '0; prev_c = 1'b0; prev_l = 1'b0;
      end else begin
        if (mem_wren) begin
          wren_cnt++;
          last_wren_addr = mem_addr;
          last_wren_be   = mem_byteena;
        end
        if (c_ready) begin
          c_cnt++;
          ready_log.push_back(0);
          chk("c_pulse", 32'(prev_c), 32'h0);
          chk("c_owner", 32'(owner), 32'h0);
          chk("l_rdata_hold", l_rdata, l_hold);
          if (cq.size() == 0) begin
            checks++; errors++;
            $display("FAIL c_unexpected_ready: got ready=1 expected no pending request");
          end else begin
            e = cq.pop_front();
            if (!e.dc) chk("c_rdata", c_rdata, e.data);
          end
          c_hold = c_rdata;
        end
        if (l_ready) begin
          l_cnt++;
          ready_log.push_back(1);
          chk("l_pulse", 32'(prev_l), 32'h0);
          chk("l_owner", 32'(owner), 32'h1);
          chk("c_rdata_hold", c_rdata, c_hold);
          if (lq.size() == 0) begin
            checks++; errors++;
            $display("FAIL l_unexpected_ready: got ready=1 expected no pending request");
          end else begin
            e = lq.pop_front();
            if (!e.dc) chk("l_rdata", l_rdata, e.data);
          end
          l_hold = l_rdata;
        end
        prev_c = c_ready;
        prev_l = l_ready;
      end
    end
  end

  task automatic wait_ready(input bit port, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!(port ? l_ready : c_ready) && cyc < 60);
    if (!(port ? l_ready : c_ready)) begin
      checks++; errors++;
      $display("FAIL timeout port%0d: got no ready expected ready within 60 cycles", port);
    end
  endtask

  task automatic do_req(input bit port, input logic [23:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata);
    int cyc;
    @(posedge clk);
    #1;
    if (port) begin
      l_addr = addr; l_wstrb = wstrb; l_wdata = wdata; l_valid = 1'b1;
    end else begin
      c_addr = addr; c_valid = 1'b1;
    end
    push(port, addr, wstrb, wdata);
    wait_ready(port, cyc);
    chk(port ? "l_latency" : "c_latency", 32'(cyc), 32'(exp_lat(addr)));
    c_valid = 1'b0;
    l_valid = 1'b0;
    @(posedge clk);
  endtask

  function automatic logic [23:0] rand_addr(input int region);
    logic [23:0] a;
    case (region)
      0: a = 24'h100000 + 24'(4 * $urandom_range(0, 4095));
      1: a = 24'h104000 + 24'(4 * $urandom_range(0, 4095));
      2: a = 24'h108000 + 24'(4 * $urandom_range(0, 8191));
      default: a = 24'h200000 + 24'(4 * $urandom_range(0, 8191));
    endcase
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    int          cyc, s0, prev, w0, c0, r;
    logic [12:0] a0;
    logic [23:0] a;
    logic [3:0]  ws;

    resetn = 1'b0; c_valid = 1'b0; l_valid = 1'b0; l_lock = 1'b0;
    c_addr = '0; l_addr = '0; l_wstrb = '0; l_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c_ready", 32'(c_ready), 32'h0);
    chk("rst_l_ready", 32'(l_ready), 32'h0);
    chk("rst_mem_wren", 32'(mem_wren), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_c_rdata", c_rdata, 32'h0);
    chk("rst_l_rdata", l_rdata, 32'h0);
    chk("rst_owner", 32'(owner), 32'h1);
    resetn = 1'b1;

    // CPU read of word 1
    w0 = wren_cnt;
    do_req(1'b0, 24'h100004, 4'h0, 32'h0);
    chk("cpu_read_no_wren", 32'(wren_cnt - w0), 32'h0);

    // Loader partial write then CPU readback
    w0 = wren_cnt;
    do_req(1'b1, 24'h100010, 4'b0011, 32'h12345678);
    chk("wr_wren_cycles", 32'(wren_cnt - w0), 32'h1);
    chk("wr_mem_addr", 32'(last_wren_addr), 32'h4);
    chk("wr_byteena", 32'(last_wren_be), 32'h3);
    do_req(1'b0, 24'h100010, 4'h0, 32'h0);

    // Simultaneous, continuously held requests must alternate
    s0   = ready_log.size();
    prev = ready_log[s0-1];
    @(posedge clk);
    #1;
    c_addr = rand_addr(0);
    push(1'b0, c_addr, 4'h0, 32'h0);
    l_addr = rand_addr(1); l_wstrb = 4'(($urandom_range(0, 1) != 0) ? $urandom : 0);
    l_wdata = $urandom;
    push(1'b1, l_addr, l_wstrb, l_wdata);
    c_valid = 1'b1; l_valid = 1'b1;
    fork
      begin
        int cc;
        for (int i = 0; i < 4; i++) begin
          wait_ready(1'b0, cc);
          if (i > 0) chk("c_alt_interval", 32'(cc), 32'd8);
          if (i < 3) begin
            c_addr = rand_addr(0);
            push(1'b0, c_addr, 4'h0, 32'h0);
          end
        end
        c_valid = 1'b0;
      end
      begin
        int lc;
        for (int i = 0; i < 4; i++) begin
          wait_ready(1'b1, lc);
          if (i > 0) chk("l_alt_interval", 32'(lc), 32'd8);
          if (i < 3) begin
            l_addr = rand_addr(1); l_wstrb = 4'($urandom); l_wdata = $urandom;
            push(1'b1, l_addr, l_wstrb, l_wdata);
          end
        end
        l_valid = 1'b0;
      end
    join
    @(posedge clk);
    for (int i = 0; i < 8; i++)
      chk("alt_order", 32'(ready_log[s0+i]), 32'(((i % 2) == 0) ? (1 - prev) : prev));

    // Loader lock starves the CPU until released
    @(posedge clk);
    #1;
    l_lock = 1'b1;
    c_addr = 24'h100040;
    push(1'b0, c_addr, 4'h0, 32'h0);
    c_valid = 1'b1;
    c0 = c_cnt;
    for (int i = 0; i < 5; i++) do_req(1'b1, rand_addr(1), 4'h0, 32'h0);
    c_valid = 1'b1;
    chk("lock_blocks_cpu", 32'(c_cnt - c0), 32'h0);
    @(posedge clk);
    #1;
    l_lock = 1'b0;
    wait_ready(1'b0, cyc);
    chk("unlock_latency", 32'(cyc), 32'd3);
    c_valid = 1'b0;
    @(posedge clk);

    // Out-of-range accesses: zero data, memory untouched
    a0 = mem_addr;
    w0 = wren_cnt;
    do_req(1'b0, 24'h208000, 4'h0, 32'h0);
    do_req(1'b0, 24'h108000, 4'h0, 32'h0);
    do_req(1'b1, 24'h108004, 4'hF, 32'hCAFEF00D);
    chk("oor_mem_addr", 32'(mem_addr), 32'(a0));
    chk("oor_no_wren", 32'(wren_cnt - w0), 32'h0);

    // Randomised mix of ports, windows and strobes
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      a = rand_addr((r < 7) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 3)));
      ws = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      do_req(1'($urandom_range(0, 1)), a, ws, $urandom);
    end

    // Reset during WAIT of a loader read
    @(posedge clk);
    #1;
    l_addr = 24'h100100; l_wstrb = 4'h0; l_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst_l_ready", 32'(l_ready), 32'h0);
    chk("midrst_owner", 32'(owner), 32'h1);
    chk("midrst_mem_wren", 32'(mem_wren), 32'h0);
    l_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    c0 = l_cnt;
    repeat (4) @(posedge clk);
    chk("midrst_no_ready", 32'(l_cnt - c0), 32'h0);
    do_req(1'b0, 24'h100004, 4'h0, 32'h0);

    repeat (3) @(posedge clk);
    chk("queues_drained", 32'(cq.size() + lq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
